// File: rtl/eeg_pea_out_arb_pkg.sv
// Shared definitions for the PE output arbiter: FSM encoding and width helpers.
package eeg_pea_out_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // PE index width; a single PE still needs one bit to form an address field.
  function automatic int pe_iw_f(input int pe_num);
    return (pe_num > 1) ? $clog2(pe_num) : 1;
  endfunction

  // ORAM write address = {PE index, PE-local address}.
  function automatic int owr_aw_f(input int pe_num, input int add_aw);
    return pe_iw_f(pe_num) + add_aw;
  endfunction

endpackage

// File: rtl/eeg_pea_out_arb_rr_arb.sv
// Round-robin arbiter: the search starts just after the previous winner and wraps.
module eeg_rr_arb #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int pos;

  // Pick the first requester after last_gnt in circular order.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_gnt) + k) % N;
      if (!gnt_vld && req[pos]) begin
        gnt_vld  = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/eeg_pea_out_arb.sv
// Collects PE output words into one ORAM write stream through a round-robin
// arbiter and a single output register, and sequences one layer at a time.
module eeg_pea_out_arb
  import eeg_pea_out_arb_pkg::*;
#(
  parameter int  PE_NUM      = 16,
  parameter int  DATA_OUT_DW = 8,
  parameter int  OMUX_ADD_AW = 8,
  parameter int  CNT_DW      = 16,
  localparam int PE_IW       = pe_iw_f(PE_NUM),
  localparam int OWR_AW      = owr_aw_f(PE_NUM, OMUX_ADD_AW)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            CFG_START,
  input  logic [PE_NUM-1:0]               CFG_PE_MSK,
  input  logic [PE_NUM-1:0]               IN_VLD,
  input  logic [PE_NUM-1:0]               IN_LST,
  output logic [PE_NUM-1:0]               IN_RDY,
  input  logic [PE_NUM*DATA_OUT_DW-1:0]   IN_DAT,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0]   IN_ADD,
  output logic                            OWR_VLD,
  input  logic                            OWR_RDY,
  output logic [DATA_OUT_DW-1:0]          OWR_DAT,
  output logic [OWR_AW-1:0]               OWR_ADD,
  output logic [CNT_DW-1:0]               WR_CNT,
  output logic                            IS_IDLE,
  output logic                            DONE
);

  arb_state_e              state_q;
  logic [PE_NUM-1:0]       msk_q;
  logic [PE_NUM-1:0]       lst_seen_q;
  logic [PE_IW-1:0]        last_gnt_q;
  logic                    idle_q;
  logic                    done_q;

  logic                    owr_vld_q;
  logic [DATA_OUT_DW-1:0]  owr_dat_q;
  logic [OWR_AW-1:0]       owr_add_q;
  logic [CNT_DW-1:0]       wr_cnt_q;

  logic [PE_NUM-1:0]       req;
  logic [PE_NUM-1:0]       gnt;
  logic [PE_IW-1:0]        gnt_idx;
  logic                    gnt_vld;
  logic                    take;
  logic                    load_ok;
  logic                    acc;
  logic                    all_lst;
  logic [DATA_OUT_DW-1:0]  sel_dat;
  logic [OMUX_ADD_AW-1:0]  sel_add;
  logic                    sel_lst;

  // PEs that already delivered their last word drop out of arbitration.
  assign req     = IN_VLD & msk_q & ~lst_seen_q;
  assign take    = owr_vld_q & OWR_RDY;
  assign load_ok = (state_q == ST_RUN) && (!owr_vld_q || take);
  assign acc     = load_ok & gnt_vld;
  assign IN_RDY  = acc ? gnt : '0;
  assign all_lst = ((lst_seen_q & msk_q) == msk_q);

  assign sel_dat = IN_DAT[gnt_idx*DATA_OUT_DW +: DATA_OUT_DW];
  assign sel_add = IN_ADD[gnt_idx*OMUX_ADD_AW +: OMUX_ADD_AW];
  assign sel_lst = IN_LST[gnt_idx];

  eeg_rr_arb #(
    .N  (PE_NUM),
    .IW (PE_IW)
  ) u_rr_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Layer sequencer with registered IS_IDLE / DONE flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      msk_q      <= '0;
      lst_seen_q <= '0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CFG_START) begin
            msk_q      <= CFG_PE_MSK;
            lst_seen_q <= '0;
            state_q    <= ST_RUN;
            idle_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (acc && sel_lst) lst_seen_q[gnt_idx] <= 1'b1;
          if (all_lst) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!owr_vld_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  // Output register: refill on grant, otherwise empty once the word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owr_vld_q <= 1'b0;
      owr_dat_q <= '0;
      owr_add_q <= '0;
    end else if (acc) begin
      owr_vld_q <= 1'b1;
      owr_dat_q <= sel_dat;
      owr_add_q <= {gnt_idx, sel_add};
    end else if (take) begin
      owr_vld_q <= 1'b0;
    end
  end

  // Remember the last winner so the next search starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= PE_IW'(PE_NUM - 1);
    end else if (acc) begin
      last_gnt_q <= gnt_idx;
    end
  end

  // Saturating count of accepted ORAM writes, cleared when a layer is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
    end else if (state_q == ST_IDLE && CFG_START) begin
      wr_cnt_q <= '0;
    end else if (take && !(&wr_cnt_q)) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign OWR_VLD = owr_vld_q;
  assign OWR_DAT = owr_dat_q;
  assign OWR_ADD = owr_add_q;
  assign WR_CNT  = wr_cnt_q;
  assign IS_IDLE = idle_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Directed bench for eeg_pea_out_arb with a write scoreboard.
module tb_eeg_pea_out_arb;

  localparam int PE  = 16;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int CW  = 16;
  localparam int OAW = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             CFG_START;
  logic [PE-1:0]    CFG_PE_MSK;
  logic [PE-1:0]    IN_VLD;
  logic [PE-1:0]    IN_LST;
  logic [PE-1:0]    IN_RDY;
  logic [PE*DW-1:0] IN_DAT;
  logic [PE*AW-1:0] IN_ADD;
  logic             OWR_VLD;
  logic             OWR_RDY;
  logic [DW-1:0]    OWR_DAT;
  logic [OAW-1:0]   OWR_ADD;
  logic [CW-1:0]    WR_CNT;
  logic             IS_IDLE;
  logic             DONE;

  always #5 clk = ~clk;

  eeg_pea_out_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CFG_START  (CFG_START),
    .CFG_PE_MSK (CFG_PE_MSK),
    .IN_VLD     (IN_VLD),
    .IN_LST     (IN_LST),
    .IN_RDY     (IN_RDY),
    .IN_DAT     (IN_DAT),
    .IN_ADD     (IN_ADD),
    .OWR_VLD    (OWR_VLD),
    .OWR_RDY    (OWR_RDY),
    .OWR_DAT    (OWR_DAT),
    .OWR_ADD    (OWR_ADD),
    .WR_CNT     (WR_CNT),
    .IS_IDLE    (IS_IDLE),
    .DONE       (DONE)
  );

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            nwords [PE];
  int            sent   [PE];
  bit            lst_en [PE];
  logic [PE-1:0] cur_mask;
  logic [19:0]   sb [$];
  bit            done_seen;
  int            done_cyc, last_acc_cyc, start_cyc;
  logic [19:0]   hold;

  function automatic logic [7:0] mk_dat(input int i, input int k);
    return 8'(i * 17 + k * 5 + 3);
  endfunction

  function automatic logic [7:0] mk_add(input int i, input int k);
    return 8'(i * 9 + k * 31 + 1);
  endfunction

  function automatic logic [19:0] mk_word(input int i, input int k);
    return {4'(i), mk_add(i, k), mk_dat(i, k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pes();
    for (int i = 0; i < PE; i++) begin
      IN_VLD[i]          = (sent[i] < nwords[i]);
      IN_LST[i]          = lst_en[i] && (sent[i] == nwords[i] - 1);
      IN_DAT[i*DW +: DW] = mk_dat(i, sent[i]);
      IN_ADD[i*AW +: AW] = mk_add(i, sent[i]);
    end
  endtask

  task automatic clear_pes();
    for (int i = 0; i < PE; i++) begin
      nwords[i] = 0;
      sent[i]   = 0;
      lst_en[i] = 1'b0;
    end
    drive_pes();
  endtask

  // One clock: sample at negedge, advance PE sources just after posedge.
  task automatic cycle();
    logic [PE-1:0] g;
    logic [19:0]   w;
    @(negedge clk);
    g = IN_RDY;
    chk("rdy_onehot", 32'($onehot0(g)), 1);
    chk("rdy_legal", 32'(g & ~(IN_VLD & cur_mask)), 0);
    if (OWR_VLD && OWR_RDY) begin
      last_acc_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'({OWR_ADD, OWR_DAT}), 32'hFFFFFFFF);
      end else begin
        w = sb.pop_front();
        chk("owr_word", 32'({OWR_ADD, OWR_DAT}), 32'(w));
      end
    end
    if (DONE) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < PE; i++) if (g[i]) sent[i]++;
    drive_pes();
    cyc++;
  endtask

  task automatic start_layer(input logic [PE-1:0] mask);
    CFG_PE_MSK = mask;
    CFG_START  = 1'b1;
    cur_mask   = mask;
    done_seen  = 1'b0;
    start_cyc  = cyc;
    cycle();
    CFG_START  = 1'b0;
    CFG_PE_MSK = '0;
  endtask

  task automatic run_until_done(input string tag, input int bound);
    for (int n = 0; n < bound && !done_seen; n++) cycle();
    chk(tag, 32'(done_seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    CFG_START  = 1'b0;
    CFG_PE_MSK = '0;
    OWR_RDY    = 1'b1;
    cur_mask   = '0;
    done_seen  = 1'b0;
    done_cyc   = 0;
    last_acc_cyc = 0;
    start_cyc  = 0;
    clear_pes();
    cycle();
    cycle();
    chk("rst_is_idle", 32'(IS_IDLE), 1);
    chk("rst_owr_vld", 32'(OWR_VLD), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_wr_cnt", 32'(WR_CNT), 0);
    chk("rst_owr_word", 32'({OWR_ADD, OWR_DAT}), 0);
    chk("rst_in_rdy", 32'(IN_RDY), 0);
    rst_n = 1'b1;
    cycle();

    // All 16 PEs, one word each with LST, ORAM always ready.
    for (int i = 0; i < PE; i++) begin
      nwords[i] = 1;
      lst_en[i] = 1'b1;
      sb.push_back(mk_word(i, 0));
    end
    drive_pes();
    start_layer(16'hFFFF);
    run_until_done("t1_done", 60);
    chk("t1_wr_cnt", 32'(WR_CNT), 16);
    chk("t1_done_lat", 32'(done_cyc - last_acc_cyc), 2);
    chk("t1_span", 32'(done_cyc - start_cyc), 19);
    chk("t1_sb_empty", 32'(sb.size()), 0);
    cycle();
    chk("t1_back_idle", 32'(IS_IDLE), 1);

    // PE3 and PE5 compete; grants alternate, LST only on their 4th word.
    clear_pes();
    nwords[3] = 4; lst_en[3] = 1'b1;
    nwords[5] = 4; lst_en[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk_word(3, k));
      sb.push_back(mk_word(5, k));
    end
    drive_pes();
    start_layer(16'h0028);
    run_until_done("t2_done", 60);
    chk("t2_wr_cnt", 32'(WR_CNT), 8);
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // ORAM back-pressure for 4 cycles with a word pending.
    clear_pes();
    nwords[0] = 2; lst_en[0] = 1'b1;
    nwords[1] = 2; lst_en[1] = 1'b1;
    sb.push_back(mk_word(0, 0));
    sb.push_back(mk_word(1, 0));
    sb.push_back(mk_word(0, 1));
    sb.push_back(mk_word(1, 1));
    drive_pes();
    OWR_RDY = 1'b0;
    start_layer(16'h0003);
    for (int n = 0; n < 10 && !OWR_VLD; n++) cycle();
    chk("t3_pending", 32'(OWR_VLD), 1);
    hold = {OWR_ADD, OWR_DAT};
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("t3_stall_vld", 32'(OWR_VLD), 1);
      chk("t3_stall_word", 32'({OWR_ADD, OWR_DAT}), 32'(hold));
      chk("t3_stall_rdy", 32'(IN_RDY), 0);
    end
    OWR_RDY = 1'b1;
    run_until_done("t3_done", 60);
    chk("t3_wr_cnt", 32'(WR_CNT), 4);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Only PE0 masked in; PE1 requests but must never be served.
    clear_pes();
    nwords[0] = 1; lst_en[0] = 1'b1;
    nwords[1] = 3; lst_en[1] = 1'b1;
    sb.push_back(mk_word(0, 0));
    drive_pes();
    start_layer(16'h0001);
    run_until_done("t4_done", 40);
    chk("t4_pe1_unsent", 32'(sent[1]), 0);
    chk("t4_wr_cnt", 32'(WR_CNT), 1);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of a layer while a word is pending.
    clear_pes();
    for (int i = 0; i < PE; i++) begin
      nwords[i] = 5;
      lst_en[i] = 1'b1;
    end
    for (int k = 0; k < 5; k++)
      for (int j = 1; j <= PE; j++) sb.push_back(mk_word(j % PE, k));
    drive_pes();
    start_layer(16'hFFFF);
    for (int n = 0; n < 40 && WR_CNT < 3; n++) cycle();
    chk("t5_pre_vld", 32'(OWR_VLD), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_owr_vld", 32'(OWR_VLD), 0);
    chk("t5_rst_is_idle", 32'(IS_IDLE), 1);
    chk("t5_rst_in_rdy", 32'(IN_RDY), 0);
    chk("t5_rst_wr_cnt", 32'(WR_CNT), 0);
    sb.delete();
    cur_mask = '0;
    clear_pes();
    cycle();
    cycle();
    rst_n = 1'b1;
    nwords[0] = 1; lst_en[0] = 1'b1;
    sb.push_back(mk_word(0, 0));
    drive_pes();
    start_layer(16'h0001);
    run_until_done("t5_done", 40);
    chk("t5_wr_cnt", 32'(WR_CNT), 1);
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // CFG_START while running must not change mask or counter.
    clear_pes();
    nwords[2] = 2; lst_en[2] = 1'b0;
    sb.push_back(mk_word(2, 0));
    sb.push_back(mk_word(2, 1));
    drive_pes();
    start_layer(16'h0004);
    for (int n = 0; n < 6; n++) cycle();
    chk("t6_wr_cnt_pre", 32'(WR_CNT), 2);
    nwords[0] = 1; lst_en[0] = 1'b1;
    drive_pes();
    CFG_PE_MSK = 16'hFFFF;
    CFG_START  = 1'b1;
    cycle();
    CFG_START  = 1'b0;
    CFG_PE_MSK = '0;
    for (int n = 0; n < 4; n++) cycle();
    chk("t6_not_idle", 32'(IS_IDLE), 0);
    chk("t6_wr_cnt_kept", 32'(WR_CNT), 2);
    chk("t6_pe0_unsent", 32'(sent[0]), 0);
    nwords[2] = 3; lst_en[2] = 1'b1;
    sb.push_back(mk_word(2, 2));
    drive_pes();
    done_seen = 1'b0;
    run_until_done("t6_done", 40);
    chk("t6_wr_cnt", 32'(WR_CNT), 3);
    chk("t6_sb_empty", 32'(sb.size()), 0);
    clear_pes();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeg_pea_out_arb.md
EEG_PEA_OUT_ARB -- requirements
Module: EEG_PEA_OUT_ARB

Interface
REQ-001 SHALL have parameter PE_NUM, default 16, the number of PE output streams (PE_ROW*PE_COL).
REQ-002 SHALL have parameter DATA_OUT_DW, default 8, the PE output data width.
REQ-003 SHALL have parameter OMUX_ADD_AW, default 8, the PE-local output address width.
REQ-004 SHALL have parameter CNT_DW, default 16, the write-counter width.
REQ-005 SHALL have a derived parameter PE_IW = $clog2(PE_NUM), and a derived parameter OWR_AW = PE_IW+OMUX_ADD_AW.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- CFG_START  in  1  one-cycle pulse that arms a layer.
- CFG_PE_MSK  in  PE_NUM  1 = PE participates; sampled on CFG_START.
- IN_VLD  in  PE_NUM  per-PE output valid.
- IN_LST  in  PE_NUM  per-PE last-output flag.
- IN_RDY  out  PE_NUM  per-PE grant/ready, at most one bit set.
- IN_DAT  in  PE_NUM*DATA_OUT_DW  per-PE output data.
- IN_ADD  in  PE_NUM*OMUX_ADD_AW  per-PE output address.
- OWR_VLD  out  1  ORAM write request.
- OWR_RDY  in  1  ORAM accepts the request.
- OWR_DAT  out  DATA_OUT_DW  write data.
- OWR_ADD  out  OWR_AW  write address.
- WR_CNT  out  CNT_DW  writes accepted this layer.
- IS_IDLE  out  1  FSM is in IDLE.
- DONE  out  1  one-cycle layer-complete pulse.

Function
REQ-007 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on CFG_START.
- RUN->DRAIN when every masked PE has delivered LST.
- DRAIN->DONE when the output register is empty.
- DONE->IDLE unconditionally after one cycle.
REQ-008 CFG_START SHALL latch CFG_PE_MSK, clear the LST-seen vector and clear WR_CNT.
REQ-009 CFG_START SHALL be ignored outside IDLE.
REQ-010 If CFG_PE_MSK is all zero at CFG_START, the FSM SHALL go RUN->DRAIN->DONE without granting.
REQ-011 Arbitration SHALL be round-robin over the requests IN_VLD & latched mask, in RUN only.
- Search starts at last_grant+1 and wraps from PE_NUM-1 to 0.
- last_grant resets to PE_NUM-1, so PE0 wins first.
REQ-012 IN_RDY[i] SHALL be asserted combinationally when state is RUN, PE i wins, and the output register is empty or is being accepted this cycle (OWR_VLD & OWR_RDY).
- IN_RDY SHALL be zero in every other case.
REQ-013 An accepted input SHALL load the output register one cycle later.
- OWR_DAT = IN_DAT[i].
- OWR_ADD = {i[PE_IW-1:0], IN_ADD[i]}.
- Latency from IN handshake to OWR_VLD is 1 cycle; throughput is 1 word/cycle while OWR_RDY=1.
REQ-014 OWR_VLD/DAT/ADD SHALL hold stable while OWR_VLD & ~OWR_RDY.
REQ-015 A simultaneous accept and refill SHALL keep OWR_VLD high with the new word.
REQ-016 An accepted input with IN_LST=1 SHALL set LST-seen[i].
- Further IN_VLD from that PE SHALL be masked out of arbitration until the next CFG_START.
REQ-017 WR_CNT SHALL increment on each OWR_VLD & OWR_RDY and saturate at all-ones.
REQ-018 DONE SHALL be high only in state DONE, after the last write has been accepted.
REQ-019 IS_IDLE SHALL be high only in IDLE.
REQ-020 IN_VLD from unmasked PEs SHALL never be granted.

Reset
REQ-021 rst_n low SHALL asynchronously force the following, including mid-layer:
- state to IDLE;
- IN_RDY, OWR_VLD and DONE to 0;
- OWR_DAT, OWR_ADD, WR_CNT, the mask and LST-seen to 0;
- last_grant to PE_NUM-1;
- IS_IDLE to 1.
REQ-022 Any pending output word SHALL be discarded by reset.

Structure
REQ-023 The FSM state encoding and the PE_IW/OWR_AW derivations SHALL live in the shared EEG package.
REQ-024 The round-robin grant logic SHALL be a sub-module EEG_RR_ARB (request, last-grant in; one-hot grant, index out), so it can be reused for the ACT/WEI feeders.

Verification
REQ-025 Bench SHALL cover: mask=0xFFFF, all 16 PEs valid with LST on their 1st word, OWR_RDY=1 -> grants PE0..PE15 in order, 16 writes, WR_CNT=16, DONE 2 cycles after the last accept.
REQ-026 Bench SHALL cover: PE3 and PE5 always valid, no LST -> grants alternate 3,5,3,5; OWR_ADD upper bits 3 then 5.
REQ-027 Bench SHALL cover: OWR_RDY held low 4 cycles with a word pending -> OWR_DAT/ADD stable, all IN_RDY=0, no word lost.
REQ-028 Bench SHALL cover: mask=0x0001 and PE1 valid -> PE1 never granted; DONE after PE0's LST.
REQ-029 Bench SHALL cover: rst_n asserted in RUN with OWR_VLD=1 -> same-cycle OWR_VLD=0, IS_IDLE=1; a later CFG_START yields WR_CNT starting from 0.
REQ-030 Bench SHALL cover: CFG_START in RUN -> ignored; mask and WR_CNT unchanged.
